// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared definitions for the instruction sequencer.
//   seqState_e - sequencer state encoding, also used by the bench to observe the FSM
//   CntWidth   - width of the performance counters
package core_seq_pkg;

    localparam int unsigned CntWidth = 64;

    typedef enum logic [2:0] {
        StResetWait = 3'd0,
        StIfReq     = 3'd1,
        StIfWait    = 3'd2,
        StExec      = 3'd3,
        StLsReq     = 3'd4,
        StLsWait    = 3'd5,
        StWb        = 3'd6,
        StHalt      = 3'd7
    } seqState_e;

endpackage

// File: rtl/perf_cnt64.sv
// perf_cnt64: free-running 64-bit event counter, wraps silently.
//   clk    - counting clock
//   rst_n  - asynchronous active-low reset, clears the count
//   enable - count this cycle
//   value  - current count
module perf_cnt64
    import core_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic [CntWidth-1:0] value
);

    logic [CntWidth-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign value = count;

endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer (fetch, execute, load/store, writeback).
//   clk, rst_n                  - clock, asynchronous active-low reset
//   if_req_valid/if_req_ready   - fetch request handshake
//   if_rsp_valid/if_rsp_ready   - fetched instruction handshake
//   inst_latch_en               - load instruction register (same cycle as fetch response)
//   dec_*                       - decoder outputs, valid while in EXEC
//   ls_req_valid/ls_req_ready   - data memory request handshake
//   ls_rsp_valid/ls_rsp_ready   - data memory response handshake
//   rf_we, pc_we                - writeback strobes
//   halted                      - stopped on ebreak until reset
//   minstret, mcycle            - retired-instruction and cycle counters
module core_seq
    import core_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    output logic                if_req_valid,
    input  logic                if_req_ready,
    input  logic                if_rsp_valid,
    output logic                if_rsp_ready,
    output logic                inst_latch_en,
    input  logic                dec_is_load,
    input  logic                dec_is_store,
    input  logic                dec_rd_we,
    input  logic                dec_is_ebreak,
    output logic                ls_req_valid,
    input  logic                ls_req_ready,
    input  logic                ls_rsp_valid,
    output logic                ls_rsp_ready,
    output logic                rf_we,
    output logic                pc_we,
    output logic                halted,
    output logic [CntWidth-1:0] minstret,
    output logic [CntWidth-1:0] mcycle
);

    seqState_e stateQ, stateD;
    // Register-write intent captured in EXEC; decoder inputs are not trusted after that cycle.
    logic      rfWePendQ, rfWePendD;
    logic      retire;

    always_comb begin
        stateD    = stateQ;
        rfWePendD = rfWePendQ;
        case (stateQ)
            StResetWait: stateD = StIfReq;
            StIfReq:     if (if_req_ready) stateD = StIfWait;
            StIfWait:    if (if_rsp_valid) stateD = StExec;
            StExec: begin
                // Load+store together behaves as a load, so only a pure store blocks rf_we.
                rfWePendD = dec_rd_we & (dec_is_load | ~dec_is_store);
                if (dec_is_ebreak) begin
                    stateD = StHalt;
                end else if (dec_is_load || dec_is_store) begin
                    stateD = StLsReq;
                end else begin
                    stateD = StWb;
                end
            end
            StLsReq:     if (ls_req_ready) stateD = StLsWait;
            StLsWait:    if (ls_rsp_valid) stateD = StWb;
            StWb:        stateD = StIfReq;
            StHalt:      stateD = StHalt;
            default:     stateD = StResetWait;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with stateQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ       <= StResetWait;
            rfWePendQ    <= 1'b0;
            if_req_valid <= 1'b0;
            if_rsp_ready <= 1'b0;
            ls_req_valid <= 1'b0;
            ls_rsp_ready <= 1'b0;
            pc_we        <= 1'b0;
            rf_we        <= 1'b0;
            halted       <= 1'b0;
        end else begin
            stateQ       <= stateD;
            rfWePendQ    <= rfWePendD;
            if_req_valid <= (stateD == StIfReq);
            if_rsp_ready <= (stateD == StIfWait);
            ls_req_valid <= (stateD == StLsReq);
            ls_rsp_ready <= (stateD == StLsWait);
            pc_we        <= (stateD == StWb);
            rf_we        <= (stateD == StWb) & rfWePendD;
            halted       <= (stateD == StHalt);
        end
    end

    assign inst_latch_en = (stateQ == StIfWait) & if_rsp_valid;
    assign retire        = (stateQ == StWb);

    perf_cnt64 instretCnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (retire),
        .value  (minstret)
    );

    perf_cnt64 cycleCnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (1'b1),
        .value  (mcycle)
    );

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;
    import core_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, inst_latch_en;
    logic        dec_is_load, dec_is_store, dec_rd_we, dec_is_ebreak;
    logic        ls_req_valid, ls_req_ready, ls_rsp_valid, ls_rsp_ready;
    logic        rf_we, pc_we, halted;
    logic [63:0] minstret, mcycle;

    int errors = 0;
    int checks = 0;

    core_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_ready  (if_rsp_ready),
        .inst_latch_en (inst_latch_en),
        .dec_is_load   (dec_is_load),
        .dec_is_store  (dec_is_store),
        .dec_rd_we     (dec_rd_we),
        .dec_is_ebreak (dec_is_ebreak),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_ready  (ls_rsp_ready),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .halted        (halted),
        .minstret      (minstret),
        .mcycle        (mcycle)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic rd, input logic eb);
        dec_is_load   = ld;
        dec_is_store  = st;
        dec_rd_we     = rd;
        dec_is_ebreak = eb;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        if_req_ready = 1'b1;
        if_rsp_valid = 1'b1;
        ls_req_ready = 1'b1;
        ls_rsp_valid = 1'b1;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (dut.stateQ !== StResetWait) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dut.stateQ, StResetWait);
        end
        checks++;
        if ({if_req_valid, if_rsp_ready, inst_latch_en, ls_req_valid, ls_rsp_ready,
             rf_we, pc_we, halted} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {if_req_valid, if_rsp_ready, inst_latch_en, ls_req_valid, ls_rsp_ready,
                      rf_we, pc_we, halted});
        end
        checks++;
        if (minstret !== 64'd0 || mcycle !== 64'd0) begin
            errors++;
            $display("FAIL reset_counters: got minstret=%0d mcycle=%0d required 0 0",
                     minstret, mcycle);
        end
        rst_n = 1'b1;  // cycle 0 starts here
    endtask

    task automatic test_alu();
        set_dec(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut.stateQ !== StResetWait || if_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_c0: got state=%0d req_valid=%b required 0 0",
                     dut.stateQ, if_req_valid);
        end
        tick();  // cycle 1
        checks++;
        if (dut.stateQ !== StIfReq || if_req_valid !== 1'b1 || inst_latch_en !== 1'b0) begin
            errors++;
            $display("FAIL alu_c1_ifreq: got state=%0d req_valid=%b latch=%b required 1 1 0",
                     dut.stateQ, if_req_valid, inst_latch_en);
        end
        tick();  // cycle 2
        checks++;
        if (dut.stateQ !== StIfWait || if_rsp_ready !== 1'b1 || inst_latch_en !== 1'b1) begin
            errors++;
            $display("FAIL alu_c2_ifwait: got state=%0d rsp_ready=%b latch=%b required 2 1 1",
                     dut.stateQ, if_rsp_ready, inst_latch_en);
        end
        tick();  // cycle 3
        checks++;
        if (dut.stateQ !== StExec || pc_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_c3_exec: got state=%0d pc_we=%b required 3 0", dut.stateQ, pc_we);
        end
        tick();  // cycle 4
        checks++;
        if (dut.stateQ !== StWb || pc_we !== 1'b1 || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL alu_c4_wb: got state=%0d pc_we=%b rf_we=%b required 6 1 1",
                     dut.stateQ, pc_we, rf_we);
        end
        tick();  // cycle 5
        checks++;
        if (minstret !== 64'd1 || mcycle !== 64'd5) begin
            errors++;
            $display("FAIL alu_counters: got minstret=%0d mcycle=%0d required 1 5",
                     minstret, mcycle);
        end
    endtask

    task automatic test_fetch_stall();
        if_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) if_req_ready = 1'b1;
            checks++;
            if (dut.stateQ !== StIfReq || if_req_valid !== 1'b1 || inst_latch_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: got state=%0d req_valid=%b latch=%b required 1 1 0",
                         i, dut.stateQ, if_req_valid, inst_latch_en);
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_store_slow();
        int  n       = 0;
        int  waitCnt = 0;
        logic seenWb = 1'b0;
        set_dec(1'b0, 1'b1, 1'b1, 1'b0);
        ls_rsp_valid = 1'b0;
        for (int i = 0; i < 40 && !seenWb; i++) begin
            tick();
            n++;
            if (ls_rsp_ready) begin
                waitCnt++;
                ls_rsp_valid = (waitCnt >= 6);
            end
            if (pc_we) seenWb = 1'b1;
        end
        checks++;
        if (n + 1 != 11) begin
            errors++;
            $display("FAIL store_latency: got %0d cycles required 11", n + 1);
        end
        checks++;
        if (rf_we !== 1'b0 || pc_we !== 1'b1) begin
            errors++;
            $display("FAIL store_wb: got rf_we=%b pc_we=%b required 0 1", rf_we, pc_we);
        end
        ls_rsp_valid = 1'b1;
        tick();
        checks++;
        if (minstret !== 64'd2 || dut.stateQ !== StIfReq) begin
            errors++;
            $display("FAIL store_retire: got minstret=%0d state=%0d required 2 1",
                     minstret, dut.stateQ);
        end
    endtask

    task automatic test_load_store_both();
        set_dec(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        checks++;
        if (dut.stateQ !== StLsReq || ls_req_valid !== 1'b1 || ls_rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_lsreq: got state=%0d req_valid=%b rsp_ready=%b required 4 1 0",
                     dut.stateQ, ls_req_valid, ls_rsp_ready);
        end
        tick();
        checks++;
        if (dut.stateQ !== StLsWait || ls_rsp_ready !== 1'b1 || ls_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_lswait: got state=%0d rsp_ready=%b req_valid=%b required 5 1 0",
                     dut.stateQ, ls_rsp_ready, ls_req_valid);
        end
        tick();
        checks++;
        if (rf_we !== 1'b1 || pc_we !== 1'b1) begin
            errors++;
            $display("FAIL both_wb: got rf_we=%b pc_we=%b required 1 1", rf_we, pc_we);
        end
        tick();
        checks++;
        if (minstret !== 64'd3) begin
            errors++;
            $display("FAIL both_retire: got minstret=%0d required 3", minstret);
        end
    endtask

    task automatic test_reset_mid();
        set_dec(1'b1, 1'b0, 1'b1, 1'b0);
        ls_rsp_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (dut.stateQ !== StLsWait) begin
            errors++;
            $display("FAIL mid_reach_lswait: got state=%0d required 5", dut.stateQ);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut.stateQ !== StResetWait || ls_rsp_ready !== 1'b0 || minstret !== 64'd0 ||
            mcycle !== 64'd0) begin
            errors++;
            $display("FAIL mid_async: got state=%0d rsp_ready=%b minstret=%0d mcycle=%0d required 0 0 0 0",
                     dut.stateQ, ls_rsp_ready, minstret, mcycle);
        end
        @(negedge clk);
        ls_rsp_valid = 1'b1;
        rst_n        = 1'b1;
        checks++;
        if (dut.stateQ !== StResetWait || pc_we !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: got state=%0d pc_we=%b rf_we=%b required 0 0 0",
                     dut.stateQ, pc_we, rf_we);
        end
        tick();
        checks++;
        if (dut.stateQ !== StIfReq || pc_we !== 1'b0 || rf_we !== 1'b0 || minstret !== 64'd0 ||
            mcycle !== 64'd1) begin
            errors++;
            $display("FAIL mid_restart: got state=%0d pc_we=%b rf_we=%b minstret=%0d mcycle=%0d required 1 0 0 0 1",
                     dut.stateQ, pc_we, rf_we, minstret, mcycle);
        end
    endtask

    task automatic test_wrap();
        set_dec(1'b0, 1'b0, 1'b1, 1'b0);
        force dut.instretCnt.count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instretCnt.count;
        #1;
        checks++;
        if (minstret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h required ffffffffffffffff", minstret);
        end
        repeat (4) tick();
        checks++;
        if (minstret !== 64'd0) begin
            errors++;
            $display("FAIL wrap_retire: got %h required 0", minstret);
        end
    endtask

    task automatic test_ebreak();
        apply_reset();
        rst_n = 1'b1;
        set_dec(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();  // cycle 3, EXEC
        checks++;
        if (dut.stateQ !== StExec || halted !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_exec: got state=%0d halted=%b required 3 0", dut.stateQ, halted);
        end
        tick();  // cycle 4
        checks++;
        if (halted !== 1'b1 || pc_we !== 1'b0 || rf_we !== 1'b0 || if_req_valid !== 1'b0 ||
            mcycle !== 64'd4) begin
            errors++;
            $display("FAIL ebreak_halt: got halted=%b pc_we=%b rf_we=%b req_valid=%b mcycle=%0d required 1 0 0 0 4",
                     halted, pc_we, rf_we, if_req_valid, mcycle);
        end
        repeat (3) tick();  // cycle 7
        checks++;
        if (dut.stateQ !== StHalt || halted !== 1'b1 || mcycle !== 64'd7 || minstret !== 64'd0) begin
            errors++;
            $display("FAIL ebreak_absorb: got state=%0d halted=%b mcycle=%0d minstret=%0d required 7 1 7 0",
                     dut.stateQ, halted, mcycle, minstret);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_fetch_stall();
        test_store_slow();
        test_load_store_both();
        test_reset_mid();
        test_wrap();
        test_ebreak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: if_req_valid  out  1  instruction fetch request.
REQ-004 SHALL have ports: if_req_ready  in  1  fetch unit accepts request.
REQ-005 SHALL have ports: if_rsp_valid  in  1  fetched instruction available.
REQ-006 SHALL have ports: if_rsp_ready  out  1  sequencer accepts instruction.
REQ-007 SHALL have ports: inst_latch_en  out  1  load instruction register.
REQ-008 SHALL have ports: dec_is_load  in  1  decoded load (register-file input from memory).
REQ-009 SHALL have ports: dec_is_store  in  1  decoded store (memory write enable).
REQ-010 SHALL have ports: dec_rd_we  in  1  decoded register write enable.
REQ-011 SHALL have ports: dec_is_ebreak  in  1  decoded ebreak.
REQ-012 SHALL have ports: ls_req_valid  out  1  data memory request.
REQ-013 SHALL have ports: ls_req_ready  in  1  data memory accepts request.
REQ-014 SHALL have ports: ls_rsp_valid  in  1  data memory response (load data / store ack).
REQ-015 SHALL have ports: ls_rsp_ready  out  1  sequencer accepts response.
REQ-016 SHALL have ports: rf_we  out  1  gated register-file write strobe.
REQ-017 SHALL have ports: pc_we  out  1  PC update strobe.
REQ-018 SHALL have ports: halted  out  1  core stopped on ebreak.
REQ-019 SHALL have ports: minstret  out  64  retired-instruction count.
REQ-020 SHALL have ports: mcycle  out  64  cycles since reset.

Function
REQ-021 SHALL implement states RESET_WAIT, IF_REQ, IF_WAIT, EXEC, LS_REQ, LS_WAIT, WB, HALT.
REQ-022 SHALL count a transfer only on a cycle where valid and ready are both 1; the sequencer holds a valid high until that cycle.
REQ-023 RESET_WAIT SHALL last exactly one cycle after reset release, then go to IF_REQ.
REQ-024 IF_REQ: if_req_valid=1; SHALL go to IF_WAIT on if_req_ready.
REQ-025 IF_WAIT: if_rsp_ready=1; on if_rsp_valid, inst_latch_en=1 that cycle and next state SHALL be EXEC.
REQ-026 EXEC (one cycle, decoder inputs valid): if dec_is_ebreak, next state SHALL be HALT with no rf_we/pc_we; else if dec_is_load or dec_is_store, next state SHALL be LS_REQ; else next state SHALL be WB.
REQ-027 LS_REQ: ls_req_valid=1; SHALL go to LS_WAIT on ls_req_ready.
REQ-028 LS_WAIT: ls_rsp_ready=1; SHALL go to WB on ls_rsp_valid.
REQ-029 WB (one cycle): pc_we=1; rf_we=dec_rd_we and not dec_is_store; minstret SHALL increment; next state SHALL be IF_REQ.
REQ-030 HALT SHALL be absorbing until reset; halted=1; all valid/ready/strobe outputs SHALL be 0.
REQ-031 If both dec_is_load and dec_is_store are 1, the instruction SHALL be treated as a load (rf_we follows dec_rd_we).
REQ-032 Request and response ready are never asserted in the same state; a response arriving in the request-accept cycle SHALL be ignored until the wait state.
REQ-033 All handshake and strobe outputs SHALL be Moore (decoded from state only), except inst_latch_en, which is Mealy on if_rsp_valid.
REQ-034 mcycle SHALL increment every cycle after reset, including in HALT; both counters SHALL wrap modulo 2^64 silently.
REQ-035 Minimum instruction latency: 4 cycles for ALU ops (IF_REQ to WB with zero-wait memories); 6 cycles for load/store.

Reset
REQ-036 On rst_n=0 (asynchronous), state SHALL be RESET_WAIT; counters SHALL be 0; every output SHALL be 0.
REQ-037 Reset asserted mid-transaction SHALL abandon any outstanding request; no rf_we or pc_we SHALL be produced for the aborted instruction.

Structure
REQ-038 State encoding localparams SHALL be placed in a shared core package used by the bench.
REQ-039 The 64-bit counter SHALL be one sub-module, perf_cnt64 (enable, value), instantiated twice.

Verification
REQ-040 Reset release, zero-wait memories, ALU instruction -> IF_REQ at cycle 1, WB at cycle 4, pc_we=1 and rf_we=1 at cycle 4, minstret=1.
REQ-041 if_req_ready held 0 for 3 cycles -> if_req_valid stays 1 for all 4 cycles; state stays IF_REQ; no inst_latch_en.
REQ-042 Store with dec_rd_we=1, ls_rsp_valid delayed 5 cycles -> rf_we=0 in WB, pc_we=1, total 11 cycles.
REQ-043 ebreak -> halted=1 from the cycle after EXEC; mcycle keeps incrementing; minstret unchanged.
REQ-044 rst_n pulsed low during LS_WAIT -> outputs 0 immediately; after release, RESET_WAIT then IF_REQ; minstret=0.
REQ-045 Preload minstret to 2^64-1 via force, then retire one -> minstret=0.
